btn_scan_ctrl: RTL and testbench
================================

# btn_scan_ctrl

Time-multiplexed debounce controller that shares one millisecond sample tick and one shift/compare datapath across `N_BTN` push-buttons. Each tick it scans every button once, updates its debounced level, and queues press events into a small valid/ready event FIFO. It sits between the board button pins and the CPU's I/O register block, replacing per-button debouncers and timers.

## Interface
- `N_BTN`, 4: number of buttons scanned; must satisfy 1 ≤ N_BTN ≤ 16.
- `TICK_DIV`, 50000: `clk` cycles per sample tick (1 ms at 50 MHz); must be > N_BTN + 1.
- `SHIFT_W`, 8: consecutive equal samples required to change a debounced level.
- `EVT_DEPTH`, 4: event FIFO depth; must be a power of two.
- `clk` in 1: single system clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in N_BTN: asynchronous raw button pins.
- `btn_level` out N_BTN: debounced levels.
- `btn_press` out N_BTN: one-cycle pulse per debounced 0→1 transition.
- `evt_valid` out 1: FIFO head holds an event.
- `evt_id` out clog2(N_BTN) (min 1): button index of head event.
- `evt_rel` out 1: head event is a release (see Configuration).
- `evt_ready` in 1: consumer accepts head event.
- `evt_ovf` out 1: sticky; an event was dropped because the FIFO was full.

## Operation
- `btn_raw` passes through a 2-flop synchronizer per bit; only the synchronized value is sampled.
- Tick counter counts 0..TICK_DIV-1 and wraps. `tick` is asserted in the cycle the counter equals TICK_DIV-1.
- Scan FSM:
  - IDLE → SCAN on `tick`, with idx=0.
  - SCAN processes one button per cycle: idx increments; after idx=N_BTN-1 the FSM returns to IDLE.
- Per-button update at index i, where s_i is that button's shift register:
  - s_i ← {s_i[SHIFT_W-2:0], sync[i]}.
  - If the new s_i is all ones and `btn_level[i]`=0: set level to 1, pulse `btn_press[i]`, and push event (id=i, rel=0).
  - If the new s_i is all zeros and level=1: clear level; a release event is pushed only with the macro enabled.
  - Any other pattern leaves the level unchanged.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Push while full without a simultaneous pop: event dropped, `evt_ovf` set.
  - `evt_ovf` clears only on `rst`.
- Handshake:
  - Pop on `evt_valid && evt_ready`.
  - `evt_id`/`evt_rel` stay stable while `evt_valid && !evt_ready`.
  - `evt_ready` while `evt_valid`=0 has no effect.

## Timing
- Reset values:
  - `btn_level`=0, `btn_press`=0, `evt_valid`=0, `evt_id`=0, `evt_rel`=0, `evt_ovf`=0.
  - All shift registers and synchronizer flops 0, FSM in IDLE, tick counter 0.
- With `tick` in cycle T, button i is processed in cycle T+1+i. Its `btn_level`, `btn_press` and FIFO push are registered at the end of that cycle and are visible in cycle T+2+i.
- `btn_press` is high for exactly one cycle.
- Show-ahead FIFO: when pushing into an empty FIFO, `evt_valid` rises in cycle T+2+i.
- Press latency: from a stable raw change, 2 cycles of synchronization plus SHIFT_W ticks, to within one tick period.
- `rst` mid-scan abandons the scan and clears all state. The tick counter restarts so the first `tick` follows TICK_DIV-1 cycles after reset release.
- All outputs are registered; there are no combinational input→output paths except the FIFO head, which depends only on internal state.

## Configuration
- `BTN_RELEASE_EVT_EN`:
  - Defined: debounced 1→0 transitions push events with `evt_rel`=1.
  - Undefined: release transitions update `btn_level` only, push nothing, and `evt_rel` is tied 0.
- Press behaviour is identical in both builds.

## Structure
- Package `btn_scan_pkg` holds:
  - The scan FSM state enum (IDLE, SCAN).
  - The event record type (id, rel).
  - A clog2 helper constant function.
- Sub-module `btn_evt_fifo`: parameterized synchronous show-ahead FIFO with full/empty outputs and simultaneous push/pop support.
- The synchronizer, tick counter, FSM and shift registers live in the top module.

## Test plan
All scenarios use N_BTN=4, TICK_DIV=10, SHIFT_W=4, EVT_DEPTH=4.

- **Reset:** hold `rst` 3 cycles with `btn_raw`=4'hF → all outputs 0; the first `tick` falls 9 cycles after reset release.
- **Clean press:** `btn_raw[2]`=1, held → `btn_level[2]` rises 4–5 ticks later, in cycle tick+4, with a one-cycle `btn_press[2]`. `evt_valid`=1 with `evt_id`=2, `evt_rel`=0.
- **Bounce:** `btn_raw[0]` toggles every 7 cycles for 60 cycles, then holds 0 → no level change, no press, no event.
- **Simultaneous press:** all 4 buttons pressed in the same cycle → 4 events queued in id order 0,1,2,3, pushed on consecutive cycles. `evt_ready`=0 throughout → FIFO full, `evt_ovf`=0.
- **Overflow:** with the FIFO full, press and debounce button 1 again after a release → event dropped and `evt_ovf`=1. Then with `evt_ready`=1 → heads 0,1,2,3 pop, one per cycle.
- **Release:** press then release button 3. With `BTN_RELEASE_EVT_EN` → second event id=3, rel=1. Without the macro → only the press event is queued and `btn_level[3]` returns to 0.

Source files
------------

// File: rtl/btn_scan_pkg.sv
// Shared types and helpers for the time-multiplexed button scan controller.
package btn_scan_pkg;

    localparam int EVT_ID_W = 4;  // covers the largest supported button count (16)

    typedef enum logic {IDLE, SCAN} scan_state_t;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic                rel;
    } btn_evt_t;

    function automatic int btn_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous show-ahead event FIFO; push and pop in the same cycle are both
// honoured, including when full.
module btn_evt_fifo
    import btn_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  btn_evt_t wdata,
    input  logic     pop,
    output btn_evt_t rdata,
    output logic     full,
    output logic     empty
);
    localparam int AW = btn_clog2(DEPTH);

    btn_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the outputs are defined from reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Shared-tick debounce controller scanning N_BTN buttons through one datapath.
// Define BTN_RELEASE_EVT_EN to also queue release events (evt_rel=1).
module btn_scan_ctrl
    import btn_scan_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int TICK_DIV  = 50000,
    parameter int SHIFT_W   = 8,
    parameter int EVT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_BTN-1:0]             btn_raw,
    output logic [N_BTN-1:0]             btn_level,
    output logic [N_BTN-1:0]             btn_press,
    output logic                         evt_valid,
    output logic [btn_clog2(N_BTN)-1:0]  evt_id,
    output logic                         evt_rel,
    input  logic                         evt_ready,
    output logic                         evt_ovf
);
    localparam int ID_W = btn_clog2(N_BTN);
    localparam int TW   = btn_clog2(TICK_DIV);

    logic [N_BTN-1:0]              sync1, sync2;
    logic [TW-1:0]                 tick_cnt;
    logic                          tick;
    scan_state_t                   state;
    logic [ID_W-1:0]               idx;
    logic [N_BTN-1:0][SHIFT_W-1:0] shreg;
    logic [SHIFT_W-1:0]            s_next;
    logic                          rise, fall, push, pop, full, empty;
    btn_evt_t                      push_evt, head;
    logic                          unused_head;

    assign tick   = (tick_cnt == TW'(TICK_DIV-1));
    assign s_next = {shreg[idx][SHIFT_W-2:0], sync2[idx]};
    assign rise   = (state == SCAN) && (&s_next) && !btn_level[idx];
    assign fall   = (state == SCAN) && !(|s_next) && btn_level[idx];

`ifdef BTN_RELEASE_EVT_EN
    assign push         = rise || fall;
    assign push_evt.rel = fall;
    assign evt_rel      = head.rel;
`else
    assign push         = rise;
    assign push_evt.rel = 1'b0;
    assign evt_rel      = 1'b0;
`endif
    assign push_evt.id = EVT_ID_W'(idx);

    assign evt_valid   = !empty;
    assign evt_id      = head.id[ID_W-1:0];
    assign pop         = evt_valid && evt_ready;
    assign unused_head = ^head;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            tick_cnt <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            shreg     <= '0;
            btn_level <= '0;
            btn_press <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            btn_press <= '0;
            if (push && full && !pop) evt_ovf <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    shreg[idx] <= s_next;
                    if (rise) begin
                        btn_level[idx] <= 1'b1;
                        btn_press[idx] <= 1'b1;
                    end
                    if (fall) btn_level[idx] <= 1'b0;
                    if (idx == ID_W'(N_BTN-1)) state <= IDLE;
                    else                       idx   <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    btn_evt_fifo #(.DEPTH(EVT_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_evt),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Self-checking bench for btn_scan_ctrl against a cycle-indexed behavioural model.
module tb_btn_scan_ctrl;
    localparam int NB = 4, TD = 10, SW = 4, DEPTH = 4;

    logic       clk = 1'b0, rst = 1'b1, evt_ready = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_level, btn_press;
    logic       evt_valid, evt_rel, evt_ovf;
    logic [1:0] evt_id;

    int n_chk = 0, n_err = 0;

    // model: cycle index since reset release, raw history, per-button trailing run
    int         mc = 0;
    logic [3:0] rawh [0:8191];
    logic [3:0] m_lvl = '0, m_press = '0;
    logic       m_ovf = 1'b0;
    int         q[$];
    logic       last [NB];
    int         run [NB];

    btn_scan_ctrl #(.N_BTN(NB), .TICK_DIV(TD), .SHIFT_W(SW), .EVT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_rel(evt_rel), .evt_ready(evt_ready), .evt_ovf(evt_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl = '0; m_press = '0; m_ovf = 1'b0; q.delete(); mc = 0;
        for (int i = 0; i < NB; i++) begin last[i] = 1'b0; run[i] = SW; end
    endtask

    task automatic model_step(input logic [3:0] r, input logic rd, input logic rs);
        int   ev, i;
        logic s;
        if (rs) begin model_reset(); return; end
        rawh[mc] = r;
        m_press  = '0;
        ev       = -1;
        // tick at mc%TD==TD-1, button i sampled i+1 cycles later
        if (mc >= TD && (mc % TD) < NB) begin
            i = mc % TD;
            s = (mc >= 2) ? rawh[mc-2][i] : 1'b0;
            if (s == last[i]) run[i]++;
            else begin last[i] = s; run[i] = 1; end
            if (run[i] >= SW) begin
                if (s && !m_lvl[i]) begin
                    m_lvl[i] = 1'b1; m_press[i] = 1'b1; ev = i * 2;
                end else if (!s && m_lvl[i]) begin
                    m_lvl[i] = 1'b0;
`ifdef BTN_RELEASE_EVT_EN
                    ev = i * 2 + 1;
`endif
                end
            end
        end
        if (q.size() > 0 && rd) void'(q.pop_front());
        if (ev >= 0) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_ovf = 1'b1;
        end
        mc++;
    endtask

    task automatic cyc(input logic [3:0] r, input logic rd, input logic rs);
        @(posedge clk); #1;
        btn_raw = r; evt_ready = rd; rst = rs;
        @(negedge clk);
        chk("level", 32'(btn_level), 32'(m_lvl));
        chk("press", 32'(btn_press), 32'(m_press));
        chk("valid", 32'(evt_valid), 32'(q.size() != 0));
        chk("ovf",   32'(evt_ovf),   32'(m_ovf));
        if (q.size() != 0) begin
            chk("id",  32'(evt_id),  32'(q[0] >> 1));
            chk("rel", 32'(evt_rel), 32'(q[0] & 1));
        end
        model_step(r, rd, rs);
    endtask

    initial begin
        int         hold;
        logic [3:0] rv;
        model_reset();
        repeat (3)  cyc(4'hF, 1'b0, 1'b1);                 // reset with raw high
        repeat (80) cyc(4'b0100, 1'b0, 1'b0);              // clean press btn2
        repeat (10) cyc(4'b0100, 1'b1, 1'b0);              // drain
        for (int k = 0; k < 60; k++)                       // bounce btn0, release btn2
            cyc({3'b000, 1'((k / 7) % 2)}, 1'b1, 1'b0);
        repeat (60) cyc(4'h0, 1'b1, 1'b0);
        repeat (80) cyc(4'hF, 1'b0, 1'b0);                 // simultaneous press, fill FIFO
        repeat (60) cyc(4'b1101, 1'b0, 1'b0);              // release btn1
        repeat (60) cyc(4'hF, 1'b0, 1'b0);                 // re-press btn1 -> overflow
        repeat (10) cyc(4'hF, 1'b1, 1'b0);                 // drain 0,1,2,3
        repeat (60) cyc(4'b0111, 1'b1, 1'b0);              // release btn3
        for (int k = 0; k < 20 && !(mc >= TD && mc % TD == 2); k++)
            cyc(4'b0111, 1'b1, 1'b0);
        repeat (2)  cyc(4'hF, 1'b0, 1'b1);                 // reset mid-scan
        hold = 0;
        rv   = '0;
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                rv   = 4'($urandom_range(0, 15));
                hold = $urandom_range(5, 60);
            end
            hold--;
            cyc(rv, $urandom_range(0, 3) == 0, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
